// File: rtl/btb_sa.sv
// ---------------------------------------------------------------------------
// btb_sa : set-associative branch target buffer with 2-bit direction counters
//
// The fetch stage presents lookup_pc. The registered prediction appears one
// cycle later. The execute stage writes resolved branches back through the
// upd_* port. An update that misses allocates an entry, but only when the
// branch was taken. The victim is the lowest invalid way, or the way named
// by the set's round-robin pointer when the set is full.
//
// Optional feature macro: BTB_STATS_EN
//   When defined, three 32-bit activity counters are added as outputs.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   flush             synchronous invalidate of every entry
//   lookup_valid/pc   lookup request
//   pred_valid/hit/taken/target   registered prediction (all 0 when idle)
//   upd_valid/pc/taken/target     resolved branch update
//   stat_lookups/hits/allocs      activity counters (BTB_STATS_EN only)
// ---------------------------------------------------------------------------
module btb_sa #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 512,
    parameter int WAYS     = 4,
    parameter int CNT_INIT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            lookup_valid,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_valid,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_allocs
`endif
);

    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic             r_valid  [SETS][WAYS];
    logic [TAG_W-1:0] r_tag    [SETS][WAYS];
    logic [XLEN-1:0]  r_target [SETS][WAYS];
    logic [1:0]       r_cnt    [SETS][WAYS];
    logic [WAY_W-1:0] r_rr     [SETS];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [1:0]       w_lk_cnt;
    logic [XLEN-1:0]  w_lk_target;

    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [WAY_W-1:0] w_up_hit_way;
    logic             w_free_found;
    logic [WAY_W-1:0] w_free_way;
    logic [WAY_W-1:0] w_victim;
    logic             w_do_upd;
    logic             w_alloc;

    // The two low PC bits never take part in indexing or tagging.
    logic w_unused;
    assign w_unused = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};

    assign w_lk_idx = lookup_pc[IDX_W+1:2];
    assign w_lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_up_tag = upd_pc[XLEN-1:IDX_W+2];

    // Lookup reads the stored state before this edge's update lands.
    // That gives read-before-write on same-cycle collisions.
    always_comb begin
        w_lk_hit    = 1'b0;
        w_lk_cnt    = '0;
        w_lk_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
                w_lk_hit    = 1'b1;
                w_lk_cnt    = r_cnt[w_lk_idx][w];
                w_lk_target = r_target[w_lk_idx][w];
            end
        end
    end

    // The scan runs downward, so the last invalid way seen is the lowest one.
    always_comb begin
        w_up_hit     = 1'b0;
        w_up_hit_way = '0;
        w_free_found = 1'b0;
        w_free_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
                w_up_hit     = 1'b1;
                w_up_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_up_idx][w]) begin
                w_free_found = 1'b1;
                w_free_way   = WAY_W'(w);
            end
        end
    end

    assign w_victim = w_free_found ? w_free_way : r_rr[w_up_idx];
    assign w_do_upd = upd_valid && !flush;
    assign w_alloc  = w_do_upd && !w_up_hit && upd_taken;

    // Control state: prediction registers, valid bits, counters, rr pointers.
    // A flush beats a same-cycle update. It leaves the prediction path alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_cnt[s][w]   <= '0;
                end
            end
        end else begin
            pred_valid  <= lookup_valid;
            pred_hit    <= lookup_valid && w_lk_hit;
            pred_taken  <= lookup_valid && w_lk_hit && w_lk_cnt[1];
            pred_target <= (lookup_valid && w_lk_hit) ? w_lk_target : '0;
            if (flush) begin
                for (int s = 0; s < SETS; s++) begin
                    r_rr[s] <= '0;
                    for (int w = 0; w < WAYS; w++) begin
                        r_valid[s][w] <= 1'b0;
                    end
                end
            end else if (upd_valid) begin
                if (w_up_hit) begin
                    if (upd_taken && (r_cnt[w_up_idx][w_up_hit_way] != 2'd3)) begin
                        r_cnt[w_up_idx][w_up_hit_way] <= r_cnt[w_up_idx][w_up_hit_way] + 2'd1;
                    end else if (!upd_taken && (r_cnt[w_up_idx][w_up_hit_way] != 2'd0)) begin
                        r_cnt[w_up_idx][w_up_hit_way] <= r_cnt[w_up_idx][w_up_hit_way] - 2'd1;
                    end
                end else if (upd_taken) begin
                    r_valid[w_up_idx][w_victim] <= 1'b1;
                    r_cnt[w_up_idx][w_victim]   <= 2'(CNT_INIT);
                    // The pointer moves only when it actually chose the victim.
                    if (!w_free_found) begin
                        r_rr[w_up_idx] <= (WAYS == 1) ? '0 : r_rr[w_up_idx] + 1'b1;
                    end
                end
            end
        end
    end

    // Tag and target payload. It needs no reset because the valid bits gate it.
    always_ff @(posedge clk) begin
        if (w_do_upd) begin
            if (w_up_hit && upd_taken) begin
                r_target[w_up_idx][w_up_hit_way] <= upd_target;
            end else if (w_alloc) begin
                r_tag[w_up_idx][w_victim]    <= w_up_tag;
                r_target[w_up_idx][w_victim] <= upd_target;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_allocs;

    // Free-running activity counters. Only rst clears them, not flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_lookups <= '0;
            r_stat_hits    <= '0;
            r_stat_allocs  <= '0;
        end else begin
            if (lookup_valid) r_stat_lookups <= r_stat_lookups + 32'd1;
            if (lookup_valid && w_lk_hit) r_stat_hits <= r_stat_hits + 32'd1;
            if (w_alloc) r_stat_allocs <= r_stat_allocs + 32'd1;
        end
    end

    assign stat_lookups = r_stat_lookups;
    assign stat_hits    = r_stat_hits;
    assign stat_allocs  = r_stat_allocs;
`endif

endmodule

// File: tb/tb_btb_sa.sv
// ---------------------------------------------------------------------------
// tb_btb_sa : scoreboard testbench for btb_sa with default parameters.
// The driver pushes each cycle's expected prediction from a reference model.
// The monitor pops it one cycle later and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_btb_sa;

    localparam int XLEN     = 32;
    localparam int ENTRIES  = 512;
    localparam int WAYS     = 4;
    localparam int CNT_INIT = 2;
    localparam int SETS     = ENTRIES / WAYS;
    localparam int IDXB     = $clog2(SETS);

    typedef struct packed {
        logic        v;
        logic        h;
        logic        t;
        logic [31:0] tgt;
    } predT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid, pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups, stat_hits, stat_allocs;
`endif

    int checks = 0;
    int errors = 0;
    predT sbQ[$];

    btb_sa #(.XLEN(XLEN), .ENTRIES(ENTRIES), .WAYS(WAYS), .CNT_INIT(CNT_INIT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_allocs(stat_allocs)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one entry record per (set, way) plus a victim pointer per set.
    bit          mValid  [SETS][WAYS];
    int unsigned mTag    [SETS][WAYS];
    logic [31:0] mTarget [SETS][WAYS];
    int          mCnt    [SETS][WAYS];
    int          mRr     [SETS];

    function automatic int setOf(logic [31:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic int unsigned tagOf(logic [31:0] pc);
        return int'(pc >> (IDXB + 2));
    endfunction

    function automatic int findWay(logic [31:0] pc);
        int s = setOf(pc);
        for (int w = 0; w < WAYS; w++) begin
            if (mValid[s][w] && mTag[s][w] == tagOf(pc)) return w;
        end
        return -1;
    endfunction

    function automatic void modelFlush();
        for (int s = 0; s < SETS; s++) begin
            mRr[s] = 0;
            for (int w = 0; w < WAYS; w++) mValid[s][w] = 1'b0;
        end
    endfunction

    function automatic void modelReset();
        modelFlush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mCnt[s][w] = 0;
    endfunction

    function automatic predT modelLookup(logic [31:0] pc);
        predT p;
        int w = findWay(pc);
        p = '0;
        p.v = 1'b1;
        if (w >= 0) begin
            p.h   = 1'b1;
            p.t   = (mCnt[setOf(pc)][w] >= 2);
            p.tgt = mTarget[setOf(pc)][w];
        end
        return p;
    endfunction

    function automatic void modelUpdate(logic [31:0] pc, bit taken, logic [31:0] tgt);
        int s = setOf(pc);
        int w = findWay(pc);
        int victim = -1;
        if (w >= 0) begin
            if (taken) begin
                if (mCnt[s][w] < 3) mCnt[s][w] = mCnt[s][w] + 1;
                mTarget[s][w] = tgt;
            end else if (mCnt[s][w] > 0) begin
                mCnt[s][w] = mCnt[s][w] - 1;
            end
        end else if (taken) begin
            for (int i = 0; i < WAYS; i++)
                if (!mValid[s][i] && victim < 0) victim = i;
            if (victim < 0) begin
                victim = mRr[s];
                mRr[s] = (mRr[s] + 1) % WAYS;
            end
            mValid[s][victim]  = 1'b1;
            mTag[s][victim]    = tagOf(pc);
            mTarget[s][victim] = tgt;
            mCnt[s][victim]    = CNT_INIT;
        end
    endfunction

    // Drive one cycle of stimulus and record what the model expects one cycle later.
    task automatic applyStimulus(input bit lv, input logic [31:0] lpc,
                                 input bit uv, input logic [31:0] upc,
                                 input bit ut, input logic [31:0] utgt, input bit fl);
        @(negedge clk);
        lookup_valid = lv;
        lookup_pc    = lpc;
        upd_valid    = uv;
        upd_pc       = upc;
        upd_taken    = ut;
        upd_target   = utgt;
        flush        = fl;
        if (lv) sbQ.push_back(modelLookup(lpc));
        else    sbQ.push_back('0);
        if (fl) modelFlush();
        else if (uv) modelUpdate(upc, ut, utgt);
    endtask

    task automatic lookupOnly(input logic [31:0] pc);
        applyStimulus(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic updateOnly(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        applyStimulus(1'b0, '0, 1'b1, pc, taken, tgt, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops one expected prediction per cycle and compares it with the DUT.
    always @(posedge clk) begin : monitor
        predT expT;
        predT gotT;
        #1;
        if (sbQ.size() > 0) begin
            expT = sbQ.pop_front();
            gotT = {pred_valid, pred_hit, pred_taken, pred_target};
            checks++;
            if (gotT !== expT) begin
                errors++;
                $display("[TB] FAIL pred @%0t: got v=%b h=%b t=%b tgt=%h expected v=%b h=%b t=%b tgt=%h",
                         $time, gotT.v, gotT.h, gotT.t, gotT.tgt, expT.v, expT.h, expT.t, expT.tgt);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        modelReset();
        lookup_valid = 1'b1;
        lookup_pc    = 32'h1000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid",  {31'd0, pred_valid}, 32'd0);
        checkOutput("rstHit",    {31'd0, pred_hit},   32'd0);
        checkOutput("rstTaken",  {31'd0, pred_taken}, 32'd0);
        checkOutput("rstTarget", pred_target,         32'd0);
        @(negedge clk);
        lookup_valid = 1'b0;
        rst = 1'b0;

        $display("[TB] directed sequences");
        lookupOnly(32'h1000);
        updateOnly(32'h1000, 1'b1, 32'h2000);
        lookupOnly(32'h1000);
        updateOnly(32'h1000, 1'b0, 32'h0);
        lookupOnly(32'h1000);
        updateOnly(32'h1000, 1'b0, 32'h0);
        lookupOnly(32'h1000);
        updateOnly(32'h1000, 1'b0, 32'h0);
        lookupOnly(32'h1000);
        for (int i = 0; i < 4; i++) begin
            updateOnly(32'h1000, 1'b1, 32'h2000);
            lookupOnly(32'h1000);
        end
        updateOnly(32'h1000, 1'b1, 32'h3000);
        lookupOnly(32'h1000);

        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) updateOnly(32'h800 * i, 1'b1, 32'hA000 + 32'h10 * i);
        lookupOnly(32'h0000);
        lookupOnly(32'h0800);
        lookupOnly(32'h2000);

        applyStimulus(1'b1, 32'h4000, 1'b1, 32'h4000, 1'b1, 32'h4444, 1'b0);
        lookupOnly(32'h4000);
        applyStimulus(1'b1, 32'h4000, 1'b1, 32'h5000, 1'b1, 32'h5555, 1'b1);
        lookupOnly(32'h4000);
        lookupOnly(32'h5000);
        lookupOnly(32'h2000);

        $display("[TB] random phase");
        for (int i = 0; i < 3000; i++) begin
            pc = ($urandom_range(0, 7) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            applyStimulus($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 7) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3),
                          $urandom_range(0, 1) == 1, pc, $urandom_range(0, 2) != 0,
                          $urandom & 32'hFFFF_FFFC, $urandom_range(0, 63) == 0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);

        $display("[TB] asynchronous reset");
        updateOnly(32'h2000, 1'b1, 32'h7000);
        lookupOnly(32'h2000);
        @(posedge clk);
        #3;
        checkOutput("preRstValid", {31'd0, pred_valid}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midRstValid",  {31'd0, pred_valid}, 32'd0);
        checkOutput("midRstHit",    {31'd0, pred_hit},   32'd0);
        checkOutput("midRstTaken",  {31'd0, pred_taken}, 32'd0);
        checkOutput("midRstTarget", pred_target,         32'd0);
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        flush        = 1'b0;
        sbQ.delete();
        modelReset();
        @(negedge clk);
        rst = 1'b0;

        lookupOnly(32'h2000);
        updateOnly(32'h0100, 1'b1, 32'h0900);
        lookupOnly(32'h0100);
        lookupOnly(32'h0300);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
`ifdef BTB_STATS_EN
        checkOutput("statLookups", stat_lookups, 32'd3);
        checkOutput("statHits",    stat_hits,    32'd1);
        checkOutput("statAllocs",  stat_allocs,  32'd1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_sa.md
Name: btb_sa

Overview:
- Parametrised set-associative branch target buffer with 2-bit saturating direction counters.
- Generalises the fetch-stage branch predictor in three ways: configurable entry count, ways and address width; tag-indexed sets instead of a fully associative search; allocation and replacement on update.
- Sits beside the PC generator. Fetch issues a lookup and gets a registered prediction one cycle later. The execute stage writes resolved-branch updates back.

Parameters:
- XLEN, 32, width of PC and target addresses
- ENTRIES, 512, total BTB entries; power of two
- WAYS, 4, associativity; power of two, 1..8; SETS = ENTRIES/WAYS
- CNT_INIT, 2, counter value written on allocation (2 = weakly taken)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous invalidate of all entries
- lookup_valid  input  1  lookup request this cycle
- lookup_pc  input  XLEN  fetch PC
- pred_valid  output  1  prediction valid (registered lookup_valid)
- pred_hit  output  1  tag matched a valid entry
- pred_taken  output  1  hit and counter >= 2
- pred_target  output  XLEN  stored target; 0 on miss
- upd_valid  input  1  resolved branch update
- upd_pc  input  XLEN  branch PC
- upd_taken  input  1  actual direction
- upd_target  input  XLEN  actual target (meaningful when upd_taken)

Behaviour:
- Address split:
  - idx = pc[log2(SETS)+1 : 2]
  - tag = pc[XLEN-1 : log2(SETS)+2]
  - pc[1:0] ignored.
- Entry state: valid, tag, target, cnt[1:0]. Each set also holds a round-robin pointer rr[log2(WAYS)-1:0].
- Reset (rst=1, asynchronous):
  - all valid=0, cnt=0, rr=0.
  - pred_valid, pred_hit, pred_taken = 0; pred_target = 0.
  - Takes effect mid-operation with no pending state retained.
- Lookup, latency 1:
  - Set and tag compare are combinational on lookup_pc. Result is registered at the next rising edge.
  - pred_valid = lookup_valid of the previous cycle.
  - When pred_valid=0, the pred_* fields hold 0.
  - At most one way can match. The update rule guarantees this; multiple hits are an error condition and are not defined.
- Update, applied at the clock edge when upd_valid=1:
  - Hit (valid tag match in set idx):
    - cnt saturating +1 if upd_taken, -1 if not; saturates at 3 and 0.
    - target <= upd_target only when upd_taken.
  - Miss and upd_taken=1: allocate.
    - Victim = lowest-index invalid way; if none, way rr.
    - Write valid=1, tag, target, cnt=CNT_INIT.
    - rr <= rr+1, wrapping modulo WAYS. rr advances only when the victim came from rr.
  - Miss and upd_taken=0: no state change.
- Same-cycle lookup and update to the same set or entry: lookup reads pre-update state (read-before-write). The update is visible to lookups issued in the following cycle.
- flush=1 clears all valid bits and rr at the edge. Counters and targets are don't-care.
  - flush together with upd_valid: flush wins, update dropped.
  - flush together with lookup_valid: that lookup still returns its pre-flush result.
- Fully synchronous otherwise. No stall or back-pressure: one lookup and one update are accepted every cycle.

Optional Feature:
- Macro BTB_STATS_EN.
- Defined: adds outputs stat_lookups, stat_hits, stat_allocs, each 32 bits.
  - stat_lookups increments per lookup_valid; stat_hits per pred_hit cycle; stat_allocs per allocation.
  - Counters wrap at 2^32; reset to 0 by rst; not cleared by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then lookup 0x1000 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0.
- Update pc=0x1000 taken target=0x2000, then lookup 0x1000 -> pred_hit=1, pred_taken=1 (cnt=2), pred_target=0x2000.
- Same entry: two not-taken updates -> cnt 2->1->0, pred_taken=0. Four taken updates -> cnt saturates at 3. A fifth taken update with target 0x3000 -> pred_target=0x3000.
- Defaults, set 0: allocate five taken PCs 0x0000, 0x0800, 0x1000, 0x1800, 0x2000 (same idx 0, distinct tags) -> the first four fill ways 0-3; the fifth evicts way 0, so 0x0000 misses and 0x2000 hits.
- Lookup and taken update of 0x4000 in the same cycle -> that lookup misses; the next-cycle lookup hits. Assert flush with upd_valid for 0x5000 -> all lookups miss afterwards and 0x5000 is not allocated.
- Assert rst asynchronously mid-cycle with pred_valid=1 -> outputs drop to 0 before the next edge. With BTB_STATS_EN: 3 lookups with 1 hit -> stat_lookups=3, stat_hits=1.
